wide_add_ctrl: RTL and testbench

WIDE_ADD_CTRL -- requirements
Module: wide_add_ctrl

---
 rtl/wide_add_pkg.sv | 11 +
 rtl/wide_add_ctrl_adder.sv | 19 +
 rtl/wide_add_ctrl.sv | 120 ++++++++++++
 tb/tb_wide_add_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared state encoding and default sizing for the word-serial wide adder.
package wide_add_pkg;
  localparam int N_DEF     = 5;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/wide_add_ctrl_adder.sv
// N-bit ripple-carry adder; purely combinational, one word per use.
module Adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[N];
endmodule

// File: rtl/wide_add_ctrl.sv
// Word-serial add/subtract of two N*WORDS operands through one shared N-bit adder.
// One word per cycle; result, cout and ovf are valid from DONE until the next accepted start.
module wide_add_ctrl
  import wide_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);
  localparam int W  = N * WORDS;
  localparam int IW = $clog2(WORDS);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            sub_q, sub_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [N-1:0]    a_word, b_eff, add_s;
  logic            add_co;
  logic            last_word;

  // Word select and subtract inversion sit in front of the single shared adder.
  assign a_word    = a_q[idx_q*N +: N];
  assign b_eff     = sub_q ? ~b_q[idx_q*N +: N] : b_q[idx_q*N +: N];
  assign last_word = (idx_q == IW'(WORDS - 1));

  Adder #(.N(N)) u_adder (
    .a  (a_word),
    .b  (b_eff),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          carry_d = sub ? 1'b1 : cin;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = add_s;
        carry_d             = add_co;
        if (last_word) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = add_co;
          // On the top word a_word/b_eff/add_s MSBs are the full-width sign bits.
          ovf_d   = (a_word[N-1] == b_eff[N-1]) && (add_s[N-1] != a_word[N-1]);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_wide_add_ctrl.sv
// Scoreboard bench for wide_add_ctrl at N=5, WORDS=4 (20-bit operands).
module tb_wide_add_ctrl;
  localparam int N     = 5;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, cin, sub;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  wide_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Call at a negedge: drives a request and records the independently modelled result.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv);
    exp_t         e;
    logic [W-1:0] beff;
    logic [W:0]   full;
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    beff   = sv ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, beff} + (W+1)'(sv ? 1'b1 : cv);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (av[W-1] == beff[W-1]) && (full[W-1] != av[W-1]);
    sb.push_back(e);
  endtask

  task automatic wait_done(output int cycles, output int bcnt);
    cycles = 0;
    bcnt   = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({busy, done, cout, ovf} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, cout, ovf}); end
    tests++; if (sum !== '0) begin fails++; $display("FAIL reset_sum: got %h expected 00000", sum); end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_discard: busy got %b expected 0", busy); end
  endtask

  task automatic test_add_wrap();
    int   c, bc;
    exp_t e;
    launch(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_done(c, bc);
    e = sb.pop_front();
    tests++; if (c !== 4) begin fails++; $display("FAIL wrap_latency: got %0d expected 4", c); end
    tests++; if (bc !== 4) begin fails++; $display("FAIL wrap_busy_cycles: got %0d expected 4", bc); end
    tests++; if (sum !== e.sum) begin fails++; $display("FAIL wrap_sum: got %h expected %h", sum, e.sum); end
    tests++; if (cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL wrap_cout_ovf: got %b%b expected %b%b", cout, ovf, e.cout, e.ovf); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL wrap_done_pulse: done/busy got %b%b expected 00", done, busy); end
    tests++; if (sum !== e.sum || cout !== e.cout) begin fails++; $display("FAIL wrap_hold: got %h/%b expected %h/%b", sum, cout, e.sum, e.cout); end
  endtask

  task automatic test_sub();
    int   c, bc;
    exp_t e;
    launch(20'h00005, 20'h00007, 1'b1, 1'b1);
    @(negedge clk); start = 1'b0;
    tests++; if (cout !== 1'b0 || sum !== '0) begin fails++; $display("FAIL sub_accept_clear: got %h/%b expected 00000/0", sum, cout); end
    wait_done(c, bc);
    e = sb.pop_front();
    tests++; if (c !== 4) begin fails++; $display("FAIL sub_latency: got %0d expected 4", c); end
    tests++; if (sum !== e.sum) begin fails++; $display("FAIL sub_sum: got %h expected %h", sum, e.sum); end
    tests++; if (cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL sub_cout_ovf: got %b%b expected %b%b", cout, ovf, e.cout, e.ovf); end
  endtask

  task automatic test_ovf_and_cin();
    logic [W-1:0] ta [2] = '{20'h7FFFF, 20'h12345};
    logic [W-1:0] tb [2] = '{20'h00001, 20'h0ABCD};
    logic         tc [2] = '{1'b0, 1'b1};
    int   c, bc;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      launch(ta[k], tb[k], tc[k], 1'b0);
      @(negedge clk); start = 1'b0;
      wait_done(c, bc);
      e = sb.pop_front();
      tests++; if (c !== 4) begin fails++; $display("FAIL ovf_cin_latency[%0d]: got %0d expected 4", k, c); end
      tests++; if (sum !== e.sum) begin fails++; $display("FAIL ovf_cin_sum[%0d]: got %h expected %h", k, sum, e.sum); end
      tests++; if (cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL ovf_cin_flags[%0d]: got %b%b expected %b%b", k, cout, ovf, e.cout, e.ovf); end
    end
  endtask

  task automatic test_back_to_back();
    int   c, bc;
    exp_t e;
    @(negedge clk);
    launch(20'h54321, 20'h11111, 1'b0, 1'b1);
    c = 0;
    @(negedge clk);
    while (done !== 1'b1 && c < 20) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      c++;
    end
    e = sb.pop_front();
    tests++; if (c !== 4) begin fails++; $display("FAIL held_latency: got %0d expected 4", c); end
    tests++; if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL held_result: got %h/%b%b expected %h/%b%b", sum, cout, ovf, e.sum, e.cout, e.ovf); end
    launch(20'h0F0F0, 20'h0A0A0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_no_bubble: busy/done got %b%b expected 10", busy, done); end
    wait_done(c, bc);
    e = sb.pop_front();
    tests++; if (c !== 4) begin fails++; $display("FAIL b2b_latency: got %0d expected 4", c); end
    tests++; if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL b2b_result: got %h/%b%b expected %h/%b%b", sum, cout, ovf, e.sum, e.cout, e.ovf); end
  endtask

  task automatic test_reset_mid_run();
    int   c, bc;
    exp_t e;
    @(negedge clk);
    launch(20'hABCDE, 20'h13579, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; a = 20'h00FFF; b = 20'h00FFF;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    void'(sb.pop_back());
    tests++; if ({busy, done, cout, ovf} !== 4'b0) begin fails++; $display("FAIL midrst_flags: got %b expected 0000", {busy, done, cout, ovf}); end
    tests++; if (sum !== '0) begin fails++; $display("FAIL midrst_sum: got %h expected 00000", sum); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle: busy got %b expected 0", busy); end
    launch(20'h3C3C3, 20'h0FFFF, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    wait_done(c, bc);
    e = sb.pop_front();
    tests++; if (c !== 4 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL midrst_after: got %0d %h/%b%b expected 4 %h/%b%b", c, sum, cout, ovf, e.sum, e.cout, e.ovf); end
  endtask

  task automatic test_random();
    int   c, bc;
    exp_t e;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk); start = 1'b0;
      wait_done(c, bc);
      e = sb.pop_front();
      tests++; if (c !== 4 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin fails++; $display("FAIL random[%0d]: got %0d %h/%b%b expected 4 %h/%b%b", k, c, sum, cout, ovf, e.sum, e.cout, e.ovf); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_ovf_and_cin();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
